// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decode-side inputs, MEM-stage load tag, EX-side outputs.
// The master side is the datapath around the stage; the stage itself takes the slave side.
interface id_ex_if #(parameter int DW = 32);
    logic          flush;
    logic          id_valid;
    logic          id_reg_write, id_alu_src, id_branch, id_mem_write, id_mem_read;
    logic [2:0]    id_reg_dst, id_mem_to_reg, id_jump_inst_cont;
    logic [4:0]    id_alu_op;
    logic [DW-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          mem_mem_read;
    logic [4:0]    mem_dest;

    logic          ex_valid;
    logic          ex_reg_write, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read;
    logic [2:0]    ex_reg_dst, ex_mem_to_reg, ex_jump_inst_cont;
    logic [4:0]    ex_alu_op;
    logic [DW-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_dest;
    logic          stall;
    logic [31:0]   stall_cycles, flush_count;

    modport master (
        output flush, id_valid, id_reg_write, id_alu_src, id_branch, id_mem_write, id_mem_read,
               id_reg_dst, id_mem_to_reg, id_jump_inst_cont, id_alu_op,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               mem_mem_read, mem_dest,
        input  ex_valid, ex_reg_write, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read,
               ex_reg_dst, ex_mem_to_reg, ex_jump_inst_cont, ex_alu_op,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_dest,
               stall, stall_cycles, flush_count
    );

    modport slave (
        input  flush, id_valid, id_reg_write, id_alu_src, id_branch, id_mem_write, id_mem_read,
               id_reg_dst, id_mem_to_reg, id_jump_inst_cont, id_alu_op,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               mem_mem_read, mem_dest,
        output ex_valid, ex_reg_write, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read,
               ex_reg_dst, ex_mem_to_reg, ex_jump_inst_cont, ex_alu_op,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_dest,
               stall, stall_cycles, flush_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / jr hazard detection and bubble insertion.
// Define ID_EX_PERF_CNT_EN to build the saturating stall/flush performance counters.
module id_ex_stage #(parameter int DW = 32) (
    input  logic   clk,
    input  logic   rst_n,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic [2:0] reg_dst;
        logic [2:0] mem_to_reg;
        logic [2:0] jump;
        logic [4:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [DW-1:0] pc_plus4;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
    } data_t;

    ctrl_t ctrl_q, ctrl_d, id_ctrl;
    data_t data_q, data_d;
    logic  valid_q, valid_d;
    logic  [4:0] ex_dest;
    logic  uses_rt, load_use, jr_haz, stall;

    assign id_ctrl = '{reg_write: bus.id_reg_write, alu_src: bus.id_alu_src,
                       branch: bus.id_branch, mem_write: bus.id_mem_write,
                       mem_read: bus.id_mem_read, reg_dst: bus.id_reg_dst,
                       mem_to_reg: bus.id_mem_to_reg, jump: bus.id_jump_inst_cont,
                       alu_op: bus.id_alu_op};

    always_comb begin
        case (ctrl_q.reg_dst)
            3'd0:    ex_dest = data_q.rt;
            3'd1:    ex_dest = data_q.rd;
            3'd2:    ex_dest = 5'd31;
            default: ex_dest = 5'd0;
        endcase
    end

    // A zero destination is $zero and can never be a real producer.
    assign uses_rt  = !bus.id_alu_src || bus.id_mem_write;
    assign load_use = valid_q && ctrl_q.mem_read && ctrl_q.reg_write && (ex_dest != 5'd0) &&
                      ((ex_dest == bus.id_rs) || (uses_rt && ex_dest == bus.id_rt));
    assign jr_haz   = (bus.id_jump_inst_cont == 3'd2) &&
                      ((valid_q && ctrl_q.reg_write && (ex_dest != 5'd0) && ex_dest == bus.id_rs) ||
                       (bus.mem_mem_read && (bus.mem_dest != 5'd0) && bus.mem_dest == bus.id_rs));
    assign stall    = bus.id_valid && (load_use || jr_haz) && !bus.flush;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (bus.flush || stall) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else begin
            data_d  = '{pc_plus4: bus.id_pc_plus4, rs_data: bus.id_rs_data,
                        rt_data: bus.id_rt_data, imm: bus.id_imm,
                        rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd};
            ctrl_d  = bus.id_valid ? id_ctrl : '0;
            valid_d = bus.id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;

    assign stall_cycles_d = (stall && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1
                                                                       : stall_cycles_q;
    assign flush_count_d  = (bus.flush && flush_count_q != 32'hFFFF_FFFF) ? flush_count_q + 32'd1
                                                                          : flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_count  = 32'd0;
`endif

    assign bus.stall             = stall;
    assign bus.ex_valid          = valid_q;
    assign bus.ex_dest           = ex_dest;
    assign bus.ex_reg_write      = ctrl_q.reg_write;
    assign bus.ex_alu_src        = ctrl_q.alu_src;
    assign bus.ex_branch         = ctrl_q.branch;
    assign bus.ex_mem_write      = ctrl_q.mem_write;
    assign bus.ex_mem_read       = ctrl_q.mem_read;
    assign bus.ex_reg_dst        = ctrl_q.reg_dst;
    assign bus.ex_mem_to_reg     = ctrl_q.mem_to_reg;
    assign bus.ex_jump_inst_cont = ctrl_q.jump;
    assign bus.ex_alu_op         = ctrl_q.alu_op;
    assign bus.ex_pc_plus4       = data_q.pc_plus4;
    assign bus.ex_rs_data        = data_q.rs_data;
    assign bus.ex_rt_data        = data_q.rt_data;
    assign bus.ex_imm            = data_q.imm;
    assign bus.ex_rs             = data_q.rs;
    assign bus.ex_rt             = data_q.rt;
    assign bus.ex_rd             = data_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hazards, bubbles, flush priority, async reset, counters.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    id_ex_if #(.DW(32)) bus ();
    id_ex_stage #(.DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic rw, input logic asrc, input logic mw,
                       input logic mr, input logic [2:0] rdst, input logic [2:0] jmp,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] imm);
        bus.id_valid          = v;
        bus.id_reg_write      = rw;
        bus.id_alu_src        = asrc;
        bus.id_mem_write      = mw;
        bus.id_mem_read       = mr;
        bus.id_reg_dst        = rdst;
        bus.id_jump_inst_cont = jmp;
        bus.id_mem_to_reg     = {2'b00, mr};
        bus.id_alu_op         = 5'd2;
        bus.id_branch         = 1'b0;
        bus.id_rs             = rs;
        bus.id_rt             = rt;
        bus.id_rd             = rd;
        bus.id_imm            = imm;
        bus.id_pc_plus4       = 32'h0000_1000;
        bus.id_rs_data        = 32'hAAAA_0000;
        bus.id_rt_data        = 32'hBBBB_0000;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.mem_mem_read = 1'b0;
        bus.mem_dest = 5'd0;
        drv(0, 0, 0, 0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2;
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ex_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        check("rst_ex_rs", {27'd0, bus.ex_rs}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_stall_cycles", bus.stall_cycles, 32'd0);
        check("rst_flush_count", bus.flush_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw $t0,0($t1) then add $t1,$t0,$t2
        drv(1, 1, 1, 0, 1, 3'd0, 3'd0, 5'd9, 5'd8, 5'd0, 32'd0);
        check("lw_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("lw_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("lw_ex_dest", {27'd0, bus.ex_dest}, 32'd8);
        drv(1, 1, 0, 0, 0, 3'd1, 3'd0, 5'd8, 5'd10, 5'd9, 32'd0);
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("lu_bubble_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        check("lu_bubble_mr", {31'd0, bus.ex_mem_read}, 32'd0);
        check("lu_stall_released", {31'd0, bus.stall}, 32'd0);
        tick();
        check("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("add_ex_rs", {27'd0, bus.ex_rs}, 32'd8);
        check("add_ex_dest", {27'd0, bus.ex_dest}, 32'd9);
        check("cnt_after_lu", bus.stall_cycles, CNT_EN ? 32'd1 : 32'd0);

        // addi $ra,$0,4 then jr $ra
        drv(1, 1, 1, 0, 0, 3'd0, 3'd0, 5'd0, 5'd31, 5'd0, 32'd4);
        check("addi_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("addi_ex_imm", bus.ex_imm, 32'd4);
        drv(1, 0, 0, 0, 0, 3'd0, 3'd2, 5'd31, 5'd0, 5'd0, 32'd0);
        check("jr_alu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        check("jr_alu_stall_1cyc", {31'd0, bus.stall}, 32'd0);
        tick();
        check("jr_ex_jump", {29'd0, bus.ex_jump_inst_cont}, 32'd2);
        check("jr_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

        // lw $ra then jr $ra: EX hit, then MEM hit
        drv(1, 1, 1, 0, 1, 3'd0, 3'd0, 5'd29, 5'd31, 5'd0, 32'd0);
        check("lwra_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        drv(1, 0, 0, 0, 0, 3'd0, 3'd2, 5'd31, 5'd0, 5'd0, 32'd0);
        check("jr_lw_stall_ex", {31'd0, bus.stall}, 32'd1);
        tick();
        bus.mem_mem_read = 1'b1;
        bus.mem_dest = 5'd31;
        #1;
        check("jr_lw_stall_mem", {31'd0, bus.stall}, 32'd1);
        tick();
        bus.mem_mem_read = 1'b0;
        bus.mem_dest = 5'd0;
        #1;
        check("jr_lw_released", {31'd0, bus.stall}, 32'd0);
        tick();
        check("jr_lw_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("cnt_after_jr", bus.stall_cycles, CNT_EN ? 32'd4 : 32'd0);

        // lw $0 then add reading $0: no hazard on register zero
        drv(1, 1, 1, 0, 1, 3'd0, 3'd0, 5'd9, 5'd0, 5'd0, 32'd0);
        tick();
        drv(1, 1, 0, 0, 0, 3'd1, 3'd0, 5'd0, 5'd0, 5'd10, 32'd0);
        check("zero_reg_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();

        // lw $t0 then sw $t0,0($t1); flush coincident with the hazard
        drv(1, 1, 1, 0, 1, 3'd0, 3'd0, 5'd9, 5'd8, 5'd0, 32'd0);
        tick();
        drv(1, 0, 1, 1, 0, 3'd0, 3'd0, 5'd9, 5'd8, 5'd0, 32'd0);
        check("sw_uses_rt_stall", {31'd0, bus.stall}, 32'd1);
        bus.flush = 1'b1;
        #1;
        check("flush_masks_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush_ex_mem_write", {31'd0, bus.ex_mem_write}, 32'd0);
        check("flush_count", bus.flush_count, CNT_EN ? 32'd1 : 32'd0);
        tick();
        check("sw_captured", {31'd0, bus.ex_mem_write}, 32'd1);

        // lw $t3 then slti $t3,$t0,5: rt is a destination, not a source
        drv(1, 1, 1, 0, 1, 3'd0, 3'd0, 5'd9, 5'd11, 5'd0, 32'd0);
        tick();
        drv(1, 1, 1, 0, 0, 3'd0, 3'd0, 5'd8, 5'd11, 5'd0, 32'd5);
        check("slti_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();

        // Invalid slot captures with controls forced off; reg_dst decode
        drv(0, 1, 0, 0, 1, 3'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        check("invalid_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("invalid_ex_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        drv(1, 1, 0, 0, 0, 3'd2, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        check("regdst_r31", {27'd0, bus.ex_dest}, 32'd31);
        drv(1, 1, 0, 0, 0, 3'd3, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        check("regdst_other", {27'd0, bus.ex_dest}, 32'd0);
        check("regdst_other_rw", {31'd0, bus.ex_reg_write}, 32'd1);

        // Asynchronous reset mid-cycle while ex_reg_write=1, with a hazard pending in ID
        drv(1, 1, 1, 0, 1, 3'd0, 3'd0, 5'd9, 5'd8, 5'd0, 32'd0);
        tick();
        drv(1, 1, 0, 0, 0, 3'd1, 3'd0, 5'd8, 5'd10, 5'd9, 32'd0);
        check("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        check("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("async_rst_mr", {31'd0, bus.ex_mem_read}, 32'd0);
        check("async_rst_stall", {31'd0, bus.stall}, 32'd0);
        check("async_rst_cnt", bus.stall_cycles, 32'd0);
        check("async_rst_fcnt", bus.flush_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("post_rst_capture", {31'd0, bus.ex_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
